// File: rtl/ro_meas_sequencer_if.sv
// Control/result bundle between the configuration side and the ring-oscillator
// measurement sequencer; the slave modport is the sequencer's view.
interface ro_meas_sequencer_if #(
   parameter int N_RO    = 16,
   parameter int COUNT_W = 16,
   parameter int GATE_W  = 16
);
   localparam int SEL_W = $clog2(N_RO);

   logic               go_i;
   logic               abort_i;
   logic [N_RO-1:0]    ro_mask_i;
   logic [GATE_W-1:0]  gate_i;
   logic [4:0]         cfg_s_i;
   logic               ro_clk_i;
   logic [SEL_W-1:0]   ro_sel_o;
   logic [4:0]         ro_s_o;
   logic               ro_start_o;
   logic               busy_o;
   logic               done_o;
   logic [SEL_W-1:0]   rd_addr_i;
   logic [COUNT_W-1:0] rd_data_o;
   logic [N_RO-1:0]    ovf_o;

   modport master (
      output go_i, abort_i, ro_mask_i, gate_i, cfg_s_i, ro_clk_i, rd_addr_i,
      input  ro_sel_o, ro_s_o, ro_start_o, busy_o, done_o, rd_data_o, ovf_o
   );

   modport slave (
      input  go_i, abort_i, ro_mask_i, gate_i, cfg_s_i, ro_clk_i, rd_addr_i,
      output ro_sel_o, ro_s_o, ro_start_o, busy_o, done_o, rd_data_o, ovf_o
   );
endinterface

// File: rtl/ro_meas_sequencer.sv
// Sweeps the masked ring oscillators, counts muxed-output edges over a gate window
// and banks one count per oscillator. Define RO_MEAS_SAT_EN for a saturating counter.
module ro_meas_sequencer #(
   parameter int N_RO       = 16,
   parameter int COUNT_W    = 16,
   parameter int GATE_W     = 16,
   parameter int SETTLE_CYC = 4
) (
   input logic                wb_clk_i,
   input logic                wb_rst_ni,
   ro_meas_sequencer_if.slave bus
);
   localparam int SEL_W = $clog2(N_RO);
   localparam logic [GATE_W-1:0]  SETTLE_LD = GATE_W'(SETTLE_CYC - 1);
   localparam logic [COUNT_W-1:0] CNT_MAX   = '1;

   typedef enum logic [2:0] {IDLE, SETTLE, COUNT, STORE, DONE} state_t;

   state_t             state;
   logic [SEL_W-1:0]   sel_q;
   logic [4:0]         s_q;
   logic               start_q;
   logic               busy_q;
   logic               done_q;
   logic [GATE_W-1:0]  tmr;
   logic [N_RO-1:0]    mask_q;
   logic [GATE_W-1:0]  gate_q;

   logic               ro_sync_p0, ro_sync_p1, ro_edge_p2;
   logic               rise;
   logic [COUNT_W-1:0] cnt;
   logic               cnt_ovf;
   logic [COUNT_W-1:0] cnt_nxt;
   logic               ovf_inc;

   logic [COUNT_W-1:0] res_mem [N_RO];
   logic [COUNT_W-1:0] rd_data_q;
   logic [N_RO-1:0]    ovf_bank;

   logic [SEL_W:0]     first_hit;
   logic [SEL_W:0]     next_hit;
   logic               wr_en;

   // Lowest set mask bit at or above 'from'; MSB of the result flags a hit.
   function automatic logic [SEL_W:0] find_set(input logic [N_RO-1:0] m, input int from);
      logic [SEL_W:0] r;
      r = '0;
      for (int i = N_RO - 1; i >= 0; i--)
         if (m[i] && i >= from) r = {1'b1, SEL_W'(i)};
      return r;
   endfunction

   function automatic logic [COUNT_W:0] cnt_inc(input logic [COUNT_W-1:0] c);
`ifdef RO_MEAS_SAT_EN
      if (c == CNT_MAX) return {1'b1, c};
      return {1'b0, c + 1'b1};
`else
      return {c == CNT_MAX, c + 1'b1};
`endif
   endfunction

   assign first_hit = find_set(bus.ro_mask_i, 0);
   assign next_hit  = find_set(mask_q, int'(sel_q) + 1);
   assign wr_en     = (state == STORE) && !bus.abort_i;
   assign {ovf_inc, cnt_nxt} = cnt_inc(cnt);

   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_ni) begin
         state   <= IDLE;
         sel_q   <= '0;
         s_q     <= '0;
         start_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else if (bus.abort_i && state != IDLE) begin
         state   <= IDLE;
         start_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: if (bus.go_i) begin
               mask_q <= bus.ro_mask_i;
               gate_q <= (bus.gate_i == '0) ? GATE_W'(1) : bus.gate_i;
               s_q    <= bus.cfg_s_i;
               busy_q <= 1'b1;
               if (first_hit[SEL_W]) begin
                  state <= SETTLE;
                  sel_q <= first_hit[SEL_W-1:0];
                  tmr   <= SETTLE_LD;
               end else begin
                  state  <= DONE;
                  done_q <= 1'b1;
               end
            end
            SETTLE: begin
               if (tmr == '0) begin
                  state   <= COUNT;
                  start_q <= 1'b1;
                  tmr     <= gate_q - 1'b1;
               end else begin
                  tmr <= tmr - 1'b1;
               end
            end
            COUNT: begin
               if (tmr == '0) begin
                  state   <= STORE;
                  start_q <= 1'b0;
               end else begin
                  tmr <= tmr - 1'b1;
               end
            end
            STORE: begin
               if (next_hit[SEL_W]) begin
                  state <= SETTLE;
                  sel_q <= next_hit[SEL_W-1:0];
                  tmr   <= SETTLE_LD;
               end else begin
                  state  <= DONE;
                  done_q <= 1'b1;
               end
            end
            DONE: begin
               state  <= IDLE;
               busy_q <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // p0/p1 resynchronise the oscillator, p2 holds the previous level for edge detect
   always_ff @(posedge wb_clk_i) begin
      ro_sync_p0 <= bus.ro_clk_i;
      ro_sync_p1 <= ro_sync_p0;
      ro_edge_p2 <= ro_sync_p1;
   end

   assign rise = ro_sync_p1 & ~ro_edge_p2;

   // Counter is held clear through SETTLE so stale edges of the last oscillator drop out
   always_ff @(posedge wb_clk_i) begin
      if (state == SETTLE || (state == IDLE && bus.go_i)) begin
         cnt     <= '0;
         cnt_ovf <= 1'b0;
      end else if (state == COUNT && rise) begin
         cnt     <= cnt_nxt;
         cnt_ovf <= cnt_ovf | ovf_inc;
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_ni) begin
         for (int i = 0; i < N_RO; i++) res_mem[i] <= '0;
         ovf_bank  <= '0;
         rd_data_q <= '0;
      end else begin
         rd_data_q <= res_mem[bus.rd_addr_i];
         if (wr_en) begin
            res_mem[sel_q]  <= cnt;
            ovf_bank[sel_q] <= cnt_ovf;
         end
      end
   end

   assign bus.ro_sel_o   = sel_q;
   assign bus.ro_s_o     = s_q;
   assign bus.ro_start_o = start_q;
   assign bus.busy_o     = busy_q;
   assign bus.done_o     = done_q;
   assign bus.rd_data_o  = rd_data_q;
   assign bus.ovf_o      = ovf_bank;
endmodule

// File: doc/ro_meas_sequencer.md
# ro_meas_sequencer

Measurement sequencer for the ring-oscillator array. Sweeps the 16 oscillators one at a time:
- drives the mux select and oscillator start/stage controls;
- counts rising edges of the muxed oscillator output over a programmable gate window of `wb_clk_i` cycles;
- stores one count per oscillator in a readable result bank.

It sits between the user IO/configuration logic and the oscillator/mux datapath, replacing direct pad control of select and start.

## Interface
Parameters:
- `N_RO`, 16: number of oscillators; the select width is 4.
- `COUNT_W`, 16: edge-counter and result width.
- `GATE_W`, 16: gate-window length width.
- `SETTLE_CYC`, 4: idle cycles after each select change before counting.

Ports:
- `wb_clk_i`  in  1  single clock.
- `wb_rst_ni`  in  1  reset, synchronous, active-low.
- `go_i`  in  1  start sweep; accepted only in IDLE.
- `abort_i`  in  1  terminate sweep.
- `ro_mask_i`  in  N_RO  oscillators to measure; latched on go.
- `gate_i`  in  GATE_W  gate length in cycles; latched on go; 0 treated as 1.
- `cfg_s_i`  in  5  stage-select s1..s5; latched on go.
- `ro_clk_i`  in  1  muxed oscillator output, asynchronous.
- `ro_sel_o`  out  4  mux select.
- `ro_s_o`  out  5  latched stage select.
- `ro_start_o`  out  1  oscillator enable.
- `busy_o`  out  1  sweep in progress.
- `done_o`  out  1  one-cycle pulse at sweep completion.
- `rd_addr_i`  in  4  result read address.
- `rd_data_o`  out  COUNT_W  result, registered.
- `ovf_o`  out  N_RO  per-entry overflow flags.

## Operation
- States:
  - IDLE
  - SETTLE: `ro_start_o`=0, select applied, SETTLE_CYC cycles.
  - COUNT: `ro_start_o`=1, G cycles.
  - STORE: 1 cycle.
  - DONE: 1 cycle.
- IDLE + `go_i` → latch mask/gate/cfg and clear the edge counter.
  - Mask nonzero → SETTLE at the lowest set index.
  - Mask zero → DONE directly.
- SETTLE → COUNT after SETTLE_CYC cycles.
- COUNT → STORE after G cycles.
- STORE writes count and overflow to entry idx.
  - Next-higher set bit exists → SETTLE with `ro_sel_o` updated.
  - Otherwise → DONE.
- DONE → IDLE.
- `ro_clk_i` passes through a 2-flop synchronizer plus an edge register.
  - A rising edge increments the counter only when it is detected during COUNT.
  - Edges detected during SETTLE are discarded; this flushes the synchronizer of the previous oscillator.
- Unmasked entries keep their previous result and overflow flag.
- `go_i` while busy is ignored.
- `abort_i` in any non-IDLE state:
  - next state IDLE; `ro_start_o`=0 that cycle;
  - no `done_o` and no write of the current entry;
  - already-stored entries are kept.
- `abort_i` takes priority over STORE and DONE in the same cycle.
- Reset values:
  - all outputs 0;
  - `ro_sel_o`=0, `ro_s_o`=0;
  - results and `ovf_o` cleared to 0;
  - state IDLE.

## Timing
- `go_i` is sampled at edge k. `busy_o` rises at k+1 and falls in the cycle after DONE; `done_o` is high during DONE.
- Per oscillator: SETTLE_CYC + G + 1 cycles.
- Sweep of n oscillators: `done_o` is asserted n·(SETTLE_CYC+G+1)+1 cycles after k.
- Edge-to-count latency is 3 cycles; the bench accounts for it.
- Counted frequency must be below f(`wb_clk_i`)/2. Faster oscillators alias; this is documented and not detected.
- Read port:
  - `rd_data_o` is valid 1 cycle after `rd_addr_i`.
  - A simultaneous STORE to the same address returns the old value (read-before-write).
  - `ovf_o` updates in the cycle after STORE.

## Configuration
- `RO_MEAS_SAT_EN` defined:
  - the edge counter saturates at 2^COUNT_W−1;
  - the entry's `ovf_o` bit is set when an increment is blocked.
- Not defined:
  - the counter wraps modulo 2^COUNT_W;
  - the `ovf_o` bit is set on the wrap.
- In both cases the overflow bit is rewritten on every STORE of that entry.

## Test plan
- **Reset:** hold `wb_rst_ni`=0 for 2 cycles → all outputs 0; `rd_data_o`=0 for every address.
- **Single oscillator:**
  - stimulus: mask=0x0004, gate=64, `ro_clk_i` period 8 cycles;
  - response: `ro_sel_o`=2, `ro_start_o` high exactly 64 cycles, `done_o` at k+70, entry 2 = 8 (±1).
- **Sweep:**
  - stimulus: mask=0x8001, gate=16, SETTLE_CYC=4;
  - response: entries 0 and 15 written in ascending order; `done_o` at k+43; entries 1–14 unchanged.
- **Empty mask:** mask=0 → `done_o` at k+1, `busy_o` for 1 cycle, `ro_start_o` never high.
- **Abort:**
  - stimulus: `abort_i` during COUNT of the second entry of mask=0x0003;
  - response: IDLE next cycle, no `done_o`, entry 0 written, entry 1 holds its prior value.
- **Overflow:**
  - stimulus: COUNT_W=4, 20 edges in the window;
  - response: with `RO_MEAS_SAT_EN`, result=15 and ovf=1; without it, result=4 and ovf=1.
